// File: rtl/mm_stream_tx.sv
// AXI-Stream transmitter for the mm accelerator input: buffers A then B operand elements
// packed into 32-bit words, then replays the buffer as one packet with TLAST on the last word.
module mm_stream_tx #(
  parameter int unsigned M   = 8,
  parameter int unsigned N1  = 4,
  parameter int unsigned N2  = 4,
  parameter int unsigned D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [D_W-1:0] load_data,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [31:0]    m_TDATA,
  output logic           m_TVALID,
  input  logic           m_TREADY,
  output logic           m_TLAST
);

  localparam int unsigned EPW    = 32 / D_W;
  localparam int unsigned ELEMS  = M * N1 + N1 * N2;
  localparam int unsigned WORDS  = ELEMS / EPW;
  localparam int unsigned ELEM_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LOADED = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                done_q, done_d;
  logic                last_word;
  logic [31:0]         buf_q [WORDS];
  logic [WORD_W-1:0]   wr_word;
  int unsigned         wr_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      elem_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    word_d     = word_q;
    done_d     = 1'b0;
    load_ready = 1'b0;
    busy       = 1'b0;
    m_TVALID   = 1'b0;
    last_word  = (word_q == WORD_W'(WORDS - 1));
    unique case (state_q)
      FILL: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (elem_q == ELEM_W'(ELEMS - 1)) begin
            elem_d  = '0;
            state_d = LOADED;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      LOADED: begin
        if (start) begin
          word_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        busy     = 1'b1;
        m_TVALID = 1'b1;
        if (m_TREADY) begin
          if (last_word) begin
            word_d  = '0;
            done_d  = 1'b1;
            state_d = FILL;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Outputs are decoded from registered state so an async reset clears them immediately.
  assign m_TLAST = m_TVALID && last_word;
  assign m_TDATA = m_TVALID ? buf_q[word_q] : '0;
  assign done    = done_q;

  always_comb begin
    wr_word = WORD_W'(32'(elem_q) / EPW);
    wr_off  = (32'(elem_q) % EPW) * D_W;
  end

  always_ff @(posedge clk) begin
    if (load_valid && load_ready)
      buf_q[wr_word][wr_off +: D_W] <= load_data;
  end

endmodule
